// File: rtl/tbuf_bus_arbiter_pkg.sv
// Shared types and width helpers for the tristate bus arbiter.
// Widths never drop below one bit so degenerate parameters still elaborate.
package tbuf_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TURN
    } state_t;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int turn_w(input int t);
        return (t <= 2) ? 1 : $clog2(t);
    endfunction

    function automatic int hold_w(input int m);
        return (m <= 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/tbuf_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: the pointer slot has top
// priority, then ascending indices with wrap.
module rr_pick
    import tbuf_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]        req_i,
    input  logic [idx_w(N_REQ)-1:0] ptr_i,
    output logic [idx_w(N_REQ)-1:0] win_o,
    output logic                    valid_o
);

    localparam int IW = idx_w(N_REQ);

    int            j;
    logic [IW-1:0] jw;

    always_comb begin
        win_o   = '0;
        valid_o = 1'b0;
        j       = 0;
        jw      = '0;
        // Scan from the far end so the pointer slot is written last.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j = int'(ptr_i) + i;
            if (j >= N_REQ) j = j - N_REQ;
            jw = IW'(j);
            if (req_i[jw]) begin
                win_o   = jw;
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tbuf_bus_arbiter.sv
// Round-robin owner sequencer for a shared tristate net, with an
// all-off turnaround between owners and optional forced release.
module tbuf_bus_arbiter
    import tbuf_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int TURN_CYC = 1,
    parameter int MAX_HOLD = 16,
    parameter int PAD_IDX  = 0
) (
    input  logic                    CK,
    input  logic                    RST,
    input  logic [N_REQ-1:0]        req,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        en,
    output logic                    pad_oen,
    output logic [idx_w(N_REQ)-1:0] owner_id,
    output logic                    busy,
    output logic                    timeout
);

    localparam int IW = idx_w(N_REQ);
    localparam int TW = turn_w(TURN_CYC);
    localparam int HW = hold_w(MAX_HOLD);

    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYC - 1);
    localparam logic [HW-1:0] HOLD_SAT =
        (MAX_HOLD == 0) ? {HW{1'b1}} : HW'(MAX_HOLD);
    localparam logic [IW-1:0] PAD_ID = IW'(PAD_IDX);
    localparam logic [IW-1:0] LAST_ID = IW'(N_REQ - 1);

    state_t           state_q;
    logic [IW-1:0]    ptr_q;
    logic [HW-1:0]    hold_q;
    logic [TW-1:0]    turn_q;
    logic [N_REQ-1:0] gnt_q;
    logic             pad_oen_q;
    logic [IW-1:0]    owner_q;
    logic             busy_q;
    logic             timeout_q;

    logic [IW-1:0] win_d;
    logic          win_vld_d;
    logic [IW-1:0] ptr_d;
    logic          own_req_d;
    logic          hold_done_d;

    rr_pick #(
        .N_REQ(N_REQ)
    ) u_pick (
        .req_i  (req),
        .ptr_i  (ptr_q),
        .win_o  (win_d),
        .valid_o(win_vld_d)
    );

    assign own_req_d   = req[owner_q];
    assign ptr_d       = (owner_q == LAST_ID) ? '0 : owner_q + 1'b1;
    assign hold_done_d = (MAX_HOLD != 0) && (hold_q == HOLD_SAT);

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            hold_q    <= '0;
            turn_q    <= '0;
            gnt_q     <= '0;
            pad_oen_q <= 1'b1;
            owner_q   <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (win_vld_d) begin
                        state_q   <= GRANT;
                        gnt_q     <= ONE << win_d;
                        pad_oen_q <= (win_d != PAD_ID);
                        owner_q   <= win_d;
                        hold_q    <= HW'(1);
                        busy_q    <= 1'b1;
                    end
                end
                GRANT: begin
                    if (!own_req_d || hold_done_d) begin
                        state_q   <= TURN;
                        gnt_q     <= '0;
                        pad_oen_q <= 1'b1;
                        ptr_q     <= ptr_d;
                        turn_q    <= '0;
                        timeout_q <= own_req_d;
                    end else if (hold_q != HOLD_SAT) begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                TURN: begin
                    if (turn_q == TURN_LAST) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        turn_q <= turn_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt      = gnt_q;
    assign en       = gnt_q;
    assign pad_oen  = pad_oen_q;
    assign owner_id = owner_q;
    assign busy     = busy_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_tbuf_bus_arbiter.sv
// Directed vector bench for tbuf_bus_arbiter (default and MAX_HOLD=0).
module tb_tbuf_bus_arbiter;

    logic CK = 1'b0;
    always #5 CK = ~CK;

    logic       RST = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] gnt, en;
    logic       pad_oen, busy, timeout;
    logic [1:0] owner_id;

    logic       RST0 = 1'b1;
    logic [3:0] req0 = '0;
    logic [3:0] gnt0, en0;
    logic       pad_oen0, busy0, timeout0;
    logic [1:0] owner_id0;

    tbuf_bus_arbiter dut (
        .CK      (CK),
        .RST     (RST),
        .req     (req),
        .gnt     (gnt),
        .en      (en),
        .pad_oen (pad_oen),
        .owner_id(owner_id),
        .busy    (busy),
        .timeout (timeout)
    );

    tbuf_bus_arbiter #(
        .MAX_HOLD(0)
    ) dut0 (
        .CK      (CK),
        .RST     (RST0),
        .req     (req0),
        .gnt     (gnt0),
        .en      (en0),
        .pad_oen (pad_oen0),
        .owner_id(owner_id0),
        .busy    (busy0),
        .timeout (timeout0)
    );

    int n_vec = 0;
    int n_bad = 0;
    bit armed = 1'b0;
    logic [3:0] prev_en = '0;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] en;
        logic       pad;
        logic [1:0] own;
        logic       busy;
        logic       to;
    } vec_t;

    localparam int NV = 25;
    vec_t tbl[NV];

    // Invariants checked on every cycle of the default instance.
    always @(negedge CK) begin
        if (armed) begin
            n_vec++;
            if (!$onehot0(en) || gnt !== en ||
                pad_oen !== ~en[0] ||
                (prev_en != 0 && en != 0 && en != prev_en)) begin
                n_bad++;
                $display("FAIL invariant: en=%b gnt=%b pad_oen=%b prev_en=%b",
                         en, gnt, pad_oen, prev_en);
            end
            prev_en = en;
        end
    end

    task automatic chk(input string nm, input logic [3:0] e_en,
                       input logic e_pad, input logic [1:0] e_own,
                       input logic e_busy, input logic e_to);
        n_vec++;
        if (en !== e_en || gnt !== e_en || pad_oen !== e_pad ||
            owner_id !== e_own || busy !== e_busy || timeout !== e_to) begin
            n_bad++;
            $display("FAIL %s: got en=%b pad_oen=%b owner=%0d busy=%b to=%b want en=%b pad_oen=%b owner=%0d busy=%b to=%b",
                     nm, en, pad_oen, owner_id, busy, timeout,
                     e_en, e_pad, e_own, e_busy, e_to);
        end
    endtask

    task automatic chk_en(input string nm, input logic [3:0] e_en,
                          input logic e_to);
        n_vec++;
        if (en !== e_en || timeout !== e_to) begin
            n_bad++;
            $display("FAIL %s: got en=%b to=%b want en=%b to=%b",
                     nm, en, timeout, e_en, e_to);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    initial begin
        // rst, req -> en, pad_oen, owner, busy, timeout
        tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 1'b1, 2'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 4'b0100, 4'b0000, 1'b1, 2'd0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 4'b0000, 4'b0000, 1'b1, 2'd0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 4'b0001, 4'b0001, 1'b0, 2'd0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 4'b0001, 4'b0001, 1'b0, 2'd0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 4'b0000, 4'b0000, 1'b1, 2'd0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 4'b0000, 4'b0000, 1'b1, 2'd0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 4'b0010, 4'b0010, 1'b1, 2'd1, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 4'b1010, 4'b0010, 1'b1, 2'd1, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 4'b1000, 4'b0000, 1'b1, 2'd1, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 4'b1000, 4'b0000, 1'b1, 2'd1, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 4'b1000, 4'b1000, 1'b1, 2'd3, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 2'd3, 1'b1, 1'b0};
        tbl[15] = '{1'b1, 4'b0000, 4'b0000, 1'b1, 2'd0, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b0};
        tbl[17] = '{1'b0, 4'b1001, 4'b0000, 1'b1, 2'd2, 1'b1, 1'b0};
        tbl[18] = '{1'b0, 4'b1001, 4'b0000, 1'b1, 2'd2, 1'b0, 1'b0};
        tbl[19] = '{1'b0, 4'b1001, 4'b1000, 1'b1, 2'd3, 1'b1, 1'b0};
        tbl[20] = '{1'b0, 4'b0001, 4'b0000, 1'b1, 2'd3, 1'b1, 1'b0};
        tbl[21] = '{1'b0, 4'b0001, 4'b0000, 1'b1, 2'd3, 1'b0, 1'b0};
        tbl[22] = '{1'b0, 4'b0001, 4'b0001, 1'b0, 2'd0, 1'b1, 1'b0};
        tbl[23] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 2'd0, 1'b1, 1'b0};
        tbl[24] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 2'd0, 1'b0, 1'b0};

        for (int i = 0; i < NV; i++) begin
            RST = tbl[i].rst;
            req = tbl[i].req;
            tick();
            chk($sformatf("vec%0d", i), tbl[i].en, tbl[i].pad,
                tbl[i].own, tbl[i].busy, tbl[i].to);
            armed = 1'b1;
        end

        // Forced release with two contenders alternating.
        RST = 1'b1;
        req = 4'b0000;
        tick();
        RST = 1'b0;
        req = 4'b0011;
        for (int k = 0; k < 16; k++) begin
            tick();
            chk_en("hold_own0", 4'b0001, 1'b0);
        end
        tick();
        chk_en("timeout_own0", 4'b0000, 1'b1);
        tick();
        chk_en("gap_own0", 4'b0000, 1'b0);
        for (int k = 0; k < 16; k++) begin
            tick();
            chk_en("hold_own1", 4'b0010, 1'b0);
        end
        tick();
        chk_en("timeout_own1", 4'b0000, 1'b1);
        tick();
        chk_en("gap_own1", 4'b0000, 1'b0);
        tick();
        chk_en("regrant_own0", 4'b0001, 1'b0);

        // Pad driver window tracks en[0] exactly.
        RST = 1'b1;
        req = 4'b0000;
        tick();
        RST = 1'b0;
        req = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("pad_on", 4'b0001, 1'b0, 2'd0, 1'b1, 1'b0);
        end
        req = 4'b0000;
        tick();
        chk("pad_off", 4'b0000, 1'b1, 2'd0, 1'b1, 1'b0);
        tick();
        chk("pad_idle", 4'b0000, 1'b1, 2'd0, 1'b0, 1'b0);

        // Unlimited hold on the second instance.
        RST0 = 1'b1;
        req0 = 4'b0000;
        tick();
        n_vec++;
        if (en0 !== 4'b0000 || pad_oen0 !== 1'b1 || busy0 !== 1'b0 ||
            timeout0 !== 1'b0 || owner_id0 !== 2'd0) begin
            n_bad++;
            $display("FAIL nohold_reset: en=%b pad_oen=%b busy=%b to=%b owner=%0d",
                     en0, pad_oen0, busy0, timeout0, owner_id0);
        end
        RST0 = 1'b0;
        req0 = 4'b0100;
        for (int k = 0; k < 100; k++) begin
            tick();
            n_vec++;
            if (en0 !== 4'b0100 || timeout0 !== 1'b0 || busy0 !== 1'b1 ||
                owner_id0 !== 2'd2) begin
                n_bad++;
                $display("FAIL nohold_c%0d: en=%b to=%b busy=%b owner=%0d want en=0100 to=0 busy=1 owner=2",
                         k, en0, timeout0, busy0, owner_id0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
